ftdi_sync_fifo_bridge: RTL
==========================

Name: ftdi_sync_fifo_bridge

Overview:
Bidirectional bridge between an FT245-style synchronous FIFO (FTDI channel) and on-chip logic, clocked by the FTDI clock output.
- Receive side: assembles host bytes into CMD_BYTES-wide command words.
- Transmit side: streams user bytes to the host in bounded bursts.
- Supersedes the single-byte read-only command FSM in the top level; adds multi-byte commands, write path, arbitration and bus turnaround.

Parameters:
CMD_BYTES, 1, bytes per command word (1..4); first received byte lands in LSBs.
TX_BURST_MAX, 512, max bytes written per TX burst before arbitration is re-run (>=1).
RX_PRIORITY, 1, 1: RX wins when both sides are ready in IDLE; 0: alternate, starting with RX.

Ports:
clk  in  1  FTDI clock output (60 MHz); all logic on rising edge.
n_rst  in  1  async active-low reset.
ftdi_d_i  in  8  data bus input from the pad.
ftdi_d_o  out  8  data bus output to the pad.
ftdi_d_oe  out  1  pad output enable; the top-level tristate drives the bus only when this is high.
ftdi_nrxf  in  1  low = host data available.
ftdi_ntxe  in  1  low = FTDI can accept data.
ftdi_nrd  out  1  read strobe, active low, registered.
ftdi_noe  out  1  FTDI output enable, active low, registered.
ftdi_nwr  out  1  write strobe, active low.
cmd_data  out  8*CMD_BYTES  last assembled command.
cmd_valid  out  1  one-cycle pulse; cmd_data is new.
tx_data  in  8  byte to send.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  byte accepted this cycle when tx_valid && tx_ready.
busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, immediate): ftdi_nrd=1, ftdi_noe=1, ftdi_nwr=1, ftdi_d_oe=0, ftdi_d_o=0, cmd_data=0, cmd_valid=0, tx_ready=0, byte counter=0, burst counter=0, alternate flag=RX, state=IDLE.
- States: IDLE, RX_OE, RX_READ, RX_END, TX_WRITE, TX_END.
- IDLE:
  - rx_req = !ftdi_nrxf; tx_req = !ftdi_ntxe && tx_valid.
  - Both requesting: RX_PRIORITY=1 -> RX; RX_PRIORITY=0 -> side given by the alternate flag, which toggles on each granted burst.
  - Winner RX -> RX_OE. Winner TX -> TX_WRITE.
- RX_OE: ftdi_noe=0 for one cycle (bus turnaround) -> RX_READ.
- RX_READ: ftdi_nrd=0, ftdi_noe=0.
  - A byte is captured on each edge where state==RX_READ && ftdi_nrxf==0.
  - Leave to RX_END on the first edge with ftdi_nrxf==1.
- RX_END: ftdi_nrd=1, ftdi_noe=1 for one cycle -> IDLE.
- Command assembly:
  - Byte k (counter value) is written to cmd_data[8k+7:8k] of an internal shadow register.
  - On byte CMD_BYTES-1: copy the shadow to cmd_data, pulse cmd_valid the next cycle, reset the counter to 0.
  - A partial command persists across RX bursts. CMD_BYTES=1 gives one cmd_valid per byte.
- TX_WRITE:
  - ftdi_d_oe=1, ftdi_d_o=tx_data (combinational).
  - ftdi_nwr = !tx_valid (combinational, gated by state).
  - tx_ready = !ftdi_ntxe. A byte is transferred when tx_valid && !ftdi_ntxe. If ftdi_ntxe=1, the byte is not consumed and stays on the bus.
  - Burst counter increments per transfer.
  - Exit to TX_END on the edge where any of: the counter reaches TX_BURST_MAX (after that transfer), tx_valid==0, or ftdi_ntxe==1.
- TX_END: ftdi_d_oe=0, ftdi_nwr=1 for one cycle; clear the burst counter -> IDLE. The bus is never driven by both sides; at least one idle cycle separates ftdi_d_oe=1 and ftdi_noe=0.
- Outside TX_WRITE: ftdi_nwr=1, tx_ready=0.
- Reset mid-burst: strobes deassert immediately; partial command discarded.

Decomposition:
- Shared package ftdi_pkg: state encoding constants, bus width 8, active-low strobe levels.
- Sub-module cmd_assembler: byte counter, shadow register, cmd_data/cmd_valid; parameter CMD_BYTES.

Test Plan:
1. CMD_BYTES=4; host sends 0x11,0x22,0x33,0x44 in one burst -> one cmd_valid pulse, cmd_data=0x44332211; ftdi_noe falls exactly one cycle before ftdi_nrd.
2. CMD_BYTES=2; host sends 0xAA, ftdi_nrxf high 5 cycles, then 0xBB -> single cmd_valid with cmd_data=0xBBAA; no pulse after the first byte.
3. TX_BURST_MAX=4; tx_valid held high with bytes 0..9, ftdi_ntxe low -> bursts of 4,4,2 bytes, each followed by TX_END (ftdi_d_oe=0 for one cycle); host sees 0..9 in order.
4. ftdi_ntxe goes high after the 2nd byte of a burst -> 3rd byte not lost: it is the next byte written in the following burst; no duplicates.
5. RX_PRIORITY=0; ftdi_nrxf and ftdi_ntxe low with tx_valid high continuously -> grants alternate RX, TX, RX; bus never has ftdi_d_oe=1 while ftdi_noe=0.
6. Assert n_rst during RX_READ after 1 of 4 bytes -> all outputs at reset values the same cycle; next 4-byte command assembles correctly from byte 0.

Source files
------------

// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared types and constants for the FTDI sync FIFO bridge
package ftdi_pkg;

  localparam int BUS_W = 8;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OE,
    ST_RX_READ,
    ST_RX_END,
    ST_TX_WRITE,
    ST_TX_END
  } state_t;

endpackage

// File: rtl/cmd_assembler.sv
// rtl/cmd_assembler.sv - packs received bytes LSB-first into CMD_BYTES-wide command words
module cmd_assembler
  import ftdi_pkg::*;
#(
  parameter int CMD_BYTES = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       byte_valid,
  input  logic [BUS_W-1:0]           byte_data,
  output logic [BUS_W*CMD_BYTES-1:0] cmd_data,
  output logic                       cmd_valid
);

  localparam int CW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

  logic [CW-1:0]              byte_cnt;
  logic [BUS_W*CMD_BYTES-1:0] shadow;
  logic [BUS_W*CMD_BYTES-1:0] assembled;
  logic                       last_byte;

  assign last_byte = (byte_cnt == CW'(CMD_BYTES - 1));

  // Merge the incoming byte so the final byte can go straight to cmd_data.
  always_comb begin
    assembled = shadow;
    assembled[BUS_W*int'(byte_cnt) +: BUS_W] = byte_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt  <= '0;
      shadow    <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (byte_valid) begin
        shadow <= assembled;
        if (last_byte) begin
          byte_cnt  <= '0;
          cmd_data  <= assembled;
          cmd_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ftdi_sync_fifo_bridge.sv
// rtl/ftdi_sync_fifo_bridge.sv - FT245 sync FIFO bridge: RX command assembly, bounded TX bursts, arbitration
module ftdi_sync_fifo_bridge
  import ftdi_pkg::*;
#(
  parameter int CMD_BYTES    = 1,
  parameter int TX_BURST_MAX = 512,
  parameter int RX_PRIORITY  = 1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [BUS_W-1:0]           ftdi_d_i,
  output logic [BUS_W-1:0]           ftdi_d_o,
  output logic                       ftdi_d_oe,
  input  logic                       ftdi_nrxf,
  input  logic                       ftdi_ntxe,
  output logic                       ftdi_nrd,
  output logic                       ftdi_noe,
  output logic                       ftdi_nwr,
  output logic [BUS_W*CMD_BYTES-1:0] cmd_data,
  output logic                       cmd_valid,
  input  logic [BUS_W-1:0]           tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       busy
);

  localparam int BW = $clog2(TX_BURST_MAX + 1);

  state_t        state, state_next;
  logic [BW-1:0] burst_cnt;
  logic          alt_tx;
  logic          grant;
  logic          tx_xfer;
  logic          rx_byte;

  assign tx_xfer = (state == ST_TX_WRITE) && tx_valid && !ftdi_ntxe;
  assign rx_byte = (state == ST_RX_READ) && !ftdi_nrxf;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    ftdi_d_oe  = 1'b0;
    ftdi_d_o   = '0;
    ftdi_nwr   = STROBE_OFF;
    tx_ready   = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (!ftdi_nrxf && !ftdi_ntxe && tx_valid) begin
          grant      = 1'b1;
          state_next = ((RX_PRIORITY != 0) || !alt_tx) ? ST_RX_OE : ST_TX_WRITE;
        end else if (!ftdi_nrxf) begin
          grant      = 1'b1;
          state_next = ST_RX_OE;
        end else if (!ftdi_ntxe && tx_valid) begin
          grant      = 1'b1;
          state_next = ST_TX_WRITE;
        end
      end
      ST_RX_OE:   state_next = ST_RX_READ;
      ST_RX_READ: if (ftdi_nrxf) state_next = ST_RX_END;
      ST_RX_END:  state_next = ST_IDLE;
      ST_TX_WRITE: begin
        ftdi_d_oe = 1'b1;
        ftdi_d_o  = tx_data;
        ftdi_nwr  = !tx_valid;
        tx_ready  = !ftdi_ntxe;
        if (!tx_valid || ftdi_ntxe || (burst_cnt == BW'(TX_BURST_MAX - 1)))
          state_next = ST_TX_END;
      end
      ST_TX_END:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Read strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      ftdi_nrd  <= STROBE_OFF;
      ftdi_noe  <= STROBE_OFF;
      burst_cnt <= '0;
      alt_tx    <= 1'b0;
    end else begin
      state    <= state_next;
      ftdi_nrd <= (state_next == ST_RX_READ) ? STROBE_ON : STROBE_OFF;
      ftdi_noe <= (state_next == ST_RX_OE || state_next == ST_RX_READ) ? STROBE_ON : STROBE_OFF;
      if (grant)
        alt_tx <= !alt_tx;
      if (state == ST_TX_END)
        burst_cnt <= '0;
      else if (tx_xfer)
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  cmd_assembler #(.CMD_BYTES(CMD_BYTES)) u_cmd_assembler (
    .clk        (clk),
    .n_rst      (n_rst),
    .byte_valid (rx_byte),
    .byte_data  (ftdi_d_i),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid)
  );

endmodule
